// File: rtl/pp_block_sched_pkg.sv
`default_nettype none
// ==== pp_pkg: shared types and defaults for the ping-pong block scheduler ====
// ==== Rev 1.0 ====
package pp_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int BUF_LEN_DEF  = 256;
  localparam int BEAT_W_DEF   = $clog2(BUF_LEN_DEF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TAKE      = 3'd1,
    S_STREAM    = 3'd2,
    S_FLUSH     = 3'd3,
    S_WAIT_LAST = 3'd4
  } pp_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/pp_block_sched_rr_arb2.sv
`default_nettype none
// ==== rr_arb2: combinational 2-way round-robin grant, ptr picks the winner on a tie ====
// ==== Rev 1.0 ====
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pp_block_sched.sv
`default_nettype none
// ==== pp_block_sched: shares ping-pong buffer blocks between two consumers ====
// ==== Rev 1.0 ====
module pp_block_sched
  import pp_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int BUF_LEN  = BUF_LEN_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                buf_empty_i,
  output logic                buf_take_o,
  input  logic [SAMPLE_W-1:0] rd_data_i,
  input  logic                rd_valid_i,
  output logic                rd_ready_o,
  input  logic                rd_last_i,
  input  logic [1:0]          req_i,
  output logic [1:0]          gnt_o,
  output logic [SAMPLE_W-1:0] data_o,
  output logic [1:0]          valid_o,
  input  logic [1:0]          ready_i,
  output logic [1:0]          last_o,
  output logic [1:0]          done_o,
  output logic                flush_o,
  output logic                seq_err_o,
  output logic [15:0]         blk_cnt_o
);

  localparam int BW = $clog2(BUF_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BUF_LEN - 1);

  pp_sched_state_e state_q, state_d;
  logic [1:0]      gnt_q, arb_gnt, done_q;
  logic            rr_q, flushed_q, flush_q, seq_err_q;
  logic [BW-1:0]   beat_q;
  logic [15:0]     blk_cnt_q;
  logic            req_g, rdy_g, streaming, flushing, hs, at_last;
  logic            start, blk_end, credit, go_flush;

  rr_arb2 u_arb (
    .req (req_i),
    .ptr (rr_q),
    .gnt (arb_gnt)
  );

  assign req_g     = |(req_i & gnt_q);
  assign rdy_g     = |(ready_i & gnt_q);
  assign streaming = (state_q == S_STREAM);
  assign flushing  = (state_q == S_FLUSH);
  assign at_last   = (beat_q == LAST_BEAT);

  // Pure pass-through while streaming; a flush drains the buffer on its own.
  assign rd_ready_o = streaming ? rdy_g : flushing;
  assign valid_o    = streaming ? (gnt_q & {2{rd_valid_i}}) : 2'b00;
  assign last_o     = valid_o & {2{at_last}};
  assign data_o     = rd_data_i;
  assign hs         = rd_valid_i & rd_ready_o;

  assign start   = (state_q == S_IDLE) && (req_i != 2'b00) && !buf_empty_i;
  assign blk_end = (state_q == S_WAIT_LAST) && rd_last_i;
  assign credit  = blk_end && !flushed_q;

  always_comb begin
    state_d  = state_q;
    go_flush = 1'b0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_TAKE;
      S_TAKE:      state_d = S_STREAM;
      S_STREAM: begin
        // Completing the final beat wins over a same-cycle withdrawal.
        if (hs && at_last) begin
          state_d = S_WAIT_LAST;
        end else if (!req_g) begin
          state_d  = S_FLUSH;
          go_flush = 1'b1;
        end
      end
      S_FLUSH:     if (hs && at_last) state_d = S_WAIT_LAST;
      S_WAIT_LAST: if (rd_last_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      rr_q      <= 1'b0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
      flush_q   <= 1'b0;
      seq_err_q <= 1'b0;
      done_q    <= 2'b00;
      blk_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      done_q  <= credit ? gnt_q : 2'b00;

      if (start) begin
        gnt_q <= arb_gnt;
      end else if (blk_end) begin
        gnt_q <= 2'b00;
      end

      if (blk_end) begin
        rr_q <= gnt_q[0];
      end

      if (state_q == S_TAKE) begin
        beat_q    <= '0;
        flushed_q <= 1'b0;
      end else if ((streaming || flushing) && hs) begin
        beat_q <= beat_q + BW'(1);
      end

      if (go_flush) begin
        flushed_q <= 1'b1;
        flush_q   <= 1'b1;
      end

      if (rd_last_i && (state_q != S_WAIT_LAST)) begin
        seq_err_q <= 1'b1;
      end

      if (credit) begin
        blk_cnt_q <= blk_cnt_q + 16'd1;
      end
    end
  end

  assign buf_take_o = (state_q == S_TAKE);
  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign flush_o    = flush_q;
  assign seq_err_o  = seq_err_q;
  assign blk_cnt_o  = blk_cnt_q;

endmodule
`default_nettype wire

// File: doc/pp_block_sched.md
# pp_block_sched

Consumer-side scheduler for the ping-pong sample buffer. Shares completed 256-sample blocks between two block consumers (e.g. FFT engine and capture logger) with round-robin arbitration. Issues the buffer take, streams the block to the granted consumer with zero-latency ready/valid pass-through, and flushes the block if that consumer withdraws mid-block. Sits directly between the ping-pong RAM read port and the consumers.

## Interface
- SAMPLE_W, 16, sample width; must match the buffer.
- BUF_LEN, 256, samples per block; beat counter is $clog2(BUF_LEN) = 8 bits.
- clk_i  in  1  system clock.
- rst_ni  in  1  one clock; reset is asynchronous and active-low.
- buf_empty_i  in  1  buffer has no filled block.
- buf_take_o  out  1  1-clk pulse; starts read-out of the oldest filled block.
- rd_data_i  in  SAMPLE_W  buffer sample.
- rd_valid_i  in  1  buffer sample valid.
- rd_ready_o  out  1  accept buffer sample.
- rd_last_i  in  1  buffer end-of-block pulse, one cycle after the final beat.
- req_i  in  2  per-consumer request for one block; level.
- gnt_o  out  2  one-hot grant, held for the whole block.
- data_o  out  SAMPLE_W  shared sample bus; equals rd_data_i.
- valid_o  out  2  per-consumer sample valid.
- ready_i  in  2  per-consumer ready.
- last_o  out  2  marks the final beat of a block, coincident with valid_o.
- done_o  out  2  1-clk pulse after block end; flushed blocks are excluded.
- flush_o  out  1  sticky; a granted block was flushed.
- seq_err_o  out  1  sticky; rd_last_i arrived with beat count ≠ BUF_LEN.
- blk_cnt_o  out  16  blocks delivered in full; wraps at 2^16.

## Operation
- FSM states: IDLE, TAKE, STREAM, FLUSH, WAIT_LAST.
- IDLE: when req_i≠0 and !buf_empty_i, grant one consumer, then go to TAKE.
  - Grant pointer rr_q selects the preferred consumer.
  - If only one consumer requests, that consumer is granted.
- TAKE: buf_take_o=1 for exactly one cycle, then go to STREAM. Beat counter is cleared.
- STREAM:
  - rd_ready_o = ready_i[g]; valid_o[g] = rd_valid_i.
  - Each handshake increments beat; last_o[g] = valid_o[g] & (beat == BUF_LEN-1).
  - On the handshake at beat BUF_LEN-1, go to WAIT_LAST.
  - If req_i[g] drops while in STREAM, go to FLUSH in the next cycle and set flush_o.
- FLUSH:
  - valid_o=0, rd_ready_o=1; data is discarded and beats still count.
  - After the final beat, go to WAIT_LAST.
- WAIT_LAST: on rd_last_i, clear gnt_o and go to IDLE.
  - Pulse done_o[g] and increment blk_cnt_o, unless the block was flushed.
  - Toggle rr_q to the other consumer.
- rd_last_i in any state other than WAIT_LAST sets seq_err_o; the FSM ignores it otherwise.
- gnt_o changes only in IDLE and WAIT_LAST; a grant is never re-arbitrated mid-block.

## Timing
- Reset values: all outputs 0, rr_q=0 (consumer 0 preferred), FSM in IDLE, beat=0.
- Reset assertion mid-block aborts immediately. The buffer is reset on the same reset.
- Grant latency:
  - req_i and !buf_empty_i sampled in cycle n.
  - gnt_o is registered, high from n+1; buf_take_o high at n+1.
  - The first rd_valid_i is expected at n+2.
- Data path is combinational: data_o, valid_o, last_o and rd_ready_o follow the buffer and consumer in the same cycle.
- done_o[g] is asserted the cycle after rd_last_i.
- Earliest next grant is the cycle after WAIT_LAST. The back-to-back block gap is ≥3 cycles from the last beat.
- Request drop is detected one cycle late. One extra beat may still hand-shake to the consumer in that cycle; this is accepted.
- buf_empty_i is ignored outside IDLE.

## Structure
- Package pp_pkg holds:
  - the pp_sched_state_e enum;
  - SAMPLE_W_DEF=16 and BUF_LEN_DEF=256;
  - the beat-counter width constant.
- Sub-module rr_arb2 provides the 2-way round-robin grant.
  - Inputs: req, ptr. Output: one-hot grant.
  - Purely combinational; the pointer register lives in pp_block_sched.

## Test plan
- Single consumer: req_i=01, block filled → gnt_o=01 at n+1, one buf_take_o pulse, 256 beats delivered in order, last_o on beat 255, done_o[0], blk_cnt_o=1.
- Contention: req_i=11 with 4 blocks → grants ordered 0,1,0,1; blk_cnt_o=4; gnt_o never changes mid-block.
- Backpressure: ready_i[1] toggling randomly → every sample delivered exactly once, rd_ready_o mirrors ready_i[1], last_o exactly once.
- Withdraw: req_i[0] drops at beat 100 → flush_o=1, remaining beats drained, no done_o[0], blk_cnt_o unchanged, next grant goes to consumer 1.
- Empty buffer: req_i=11 and buf_empty_i=1 for 50 cycles → no grant and no buf_take_o. A block filled later is granted within 1 cycle.
- Faults: rd_last_i injected during STREAM at beat 10 → seq_err_o=1 and sticky. Async rst_ni pulsed mid-block → all outputs 0 immediately, rr_q=0.
